// File: rtl/rf_wb_buffer.sv
// Write-back buffer: lane-maps write requests, queues them, and drains one per cycle into the register file.
// Optional RF_WB_BYPASS_EN adds combinational forwarding of pending writes (byp_* ports).
module rf_wb_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_waddr,
  input  logic [DW-1:0] in_wdata,
  input  logic [1:0]    in_size,
  input  logic [1:0]    in_offset,
  output logic [3:0]    rf_wen,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [CW-1:0] count,
`ifdef RF_WB_BYPASS_EN
  input  logic [AW-1:0] byp_addr,
  output logic          byp_hit,
  output logic [3:0]    byp_mask,
  output logic [DW-1:0] byp_data,
`endif
  output logic          align_err
);

  // Handshake: a request transfers when in_valid & in_ready at the rising edge;
  // in_ready depends only on occupancy, never on a same-cycle pop.

  logic [3:0]    mem_wen_q  [DEPTH];
  logic [AW-1:0] mem_addr_q [DEPTH];
  logic [DW-1:0] mem_data_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [3:0]    rf_wen_q;
  logic [AW-1:0] rf_waddr_q;
  logic [DW-1:0] rf_wdata_q;
  logic          align_err_q;

  logic          lane_ok;
  logic [3:0]    lane_wen;
  logic [DW-1:0] lane_data;
  logic          accept, push, pop;

  always_comb begin
    lane_ok   = 1'b0;
    lane_wen  = 4'b0000;
    lane_data = '0;
    case (in_size)
      2'd0: begin
        lane_ok   = 1'b1;
        lane_wen  = 4'b0001 << in_offset;
        lane_data = {4{in_wdata[7:0]}};
      end
      2'd1: begin
        lane_ok   = ~in_offset[0];
        lane_wen  = in_offset[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{in_wdata[15:0]}};
      end
      2'd2: begin
        lane_ok   = (in_offset == 2'd0);
        lane_wen  = 4'b1111;
        lane_data = in_wdata;
      end
      default: lane_ok = 1'b0;
    endcase
  end

  assign in_ready = (count_q != CW'(DEPTH));
  assign accept   = in_valid & in_ready;
  // Misaligned and r0 requests complete the handshake but are never stored.
  assign push     = accept & lane_ok & (in_waddr != '0);
  assign pop      = (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_wen_q[wr_ptr_q]  <= lane_wen;
      mem_addr_q[wr_ptr_q] <= in_waddr;
      mem_data_q[wr_ptr_q] <= lane_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rf_wen_q    <= 4'b0000;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      align_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rf_wen_q   <= mem_wen_q[rd_ptr_q];
        rf_waddr_q <= mem_addr_q[rd_ptr_q];
        rf_wdata_q <= mem_data_q[rd_ptr_q];
        rd_ptr_q   <= rd_ptr_q + PW'(1);
      end else begin
        rf_wen_q <= 4'b0000;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (accept && !lane_ok) align_err_q <= 1'b1;
    end
  end

  assign rf_wen    = rf_wen_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign count     = count_q;
  assign align_err = align_err_q;

`ifdef RF_WB_BYPASS_EN
  logic [PW-1:0] byp_idx;

  // Scan oldest to youngest so the youngest match overwrites earlier ones.
  always_comb begin
    byp_hit  = 1'b0;
    byp_mask = 4'b0000;
    byp_data = '0;
    byp_idx  = '0;
    if (byp_addr != '0) begin
      if (rf_wen_q != 4'b0000 && rf_waddr_q == byp_addr) begin
        byp_hit  = 1'b1;
        byp_mask = rf_wen_q;
        byp_data = rf_wdata_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        byp_idx = rd_ptr_q + PW'(i);
        if (CW'(i) < count_q && mem_addr_q[byp_idx] == byp_addr) begin
          byp_hit  = 1'b1;
          byp_mask = mem_wen_q[byp_idx];
          byp_data = mem_data_q[byp_idx];
        end
      end
    end
  end
`endif

endmodule
